// File: rtl/pdm_mic_tx.sv
// Two-channel PDM microphone emulator: buffers 12-bit sample pairs and emits
// second-order delta-sigma bitstreams clocked by the host-supplied MIC_CK_i.
module pdm_mic_tx #(
    parameter int unsigned C_DEC  = 64,
    parameter int unsigned C_WARM = 1024,
    parameter int unsigned C_WDT  = 255
) (
    input  logic        CK_i,
    input  logic        XARST_i,
    input  logic        MIC_CK_i,
    input  logic        EN_i,
    input  logic [23:0] SMPLs_i,
    input  logic        SMPL_VLD_i,
    output logic        SMPL_RDY_o,
    output logic [1:0]  MICs_DAT_o,
    output logic [1:0]  STATUSs_o
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync2_q, edge_q;
    logic               rise, fall;
    logic [11:0]        warm_q, warm_d;
    logic [7:0]         frm_q, frm_d;
    logic [9:0]         wdt_q, wdt_d;
    logic [23:0]        fifo_q [2];
    logic [23:0]        fifo_d [2];
    logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [23:0]        cur_q, cur_d;
    logic signed [15:0] i1_q [2];
    logic signed [15:0] i1_d [2];
    logic signed [15:0] i2_q [2];
    logic signed [15:0] i2_d [2];
    logic [1:0]         y_q, y_d;
    logic [1:0]         status_q, status_d;
    logic               alive_q;
    logic               rdy, push, pop, timeout, mod_upd, mod_clr;
    logic [32:0]        step0, step1;

    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'sh7FFF;
        else if (v < -18'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    // Returns {y_new, i2_new, i1_new} for one modulator update.
    function automatic logic [32:0] mod_step(input logic signed [15:0] i1,
                                             input logic signed [15:0] i2,
                                             input logic               y,
                                             input logic [11:0]        x);
        logic signed [17:0] yv, s1, s2;
        logic signed [15:0] n1, n2;
        yv = y ? 18'sd2048 : -18'sd2048;
        s1 = 18'(i1) + 18'($signed(x)) - yv;
        n1 = sat16(s1);
        s2 = 18'(i2) + 18'(n1) - yv;
        n2 = sat16(s2);
        return {~n2[15], n2, n1};
    endfunction

    assign rise       = sync2_q & ~edge_q;
    assign fall       = ~sync2_q & edge_q;
    assign rdy        = alive_q & EN_i & (cnt_q != 2'd2);
    assign push       = SMPL_VLD_i & rdy;
    assign mod_clr    = (state_q != ST_RUN) | timeout | ~EN_i;
    assign SMPL_RDY_o = rdy;
    assign MICs_DAT_o = y_q;
    assign STATUSs_o  = status_q;

    always_comb begin
        state_d  = state_q;
        warm_d   = warm_q;
        frm_d    = frm_q;
        wdt_d    = wdt_q;
        status_d = status_q;
        cur_d    = cur_q;
        pop      = 1'b0;
        mod_upd  = 1'b0;
        timeout  = 1'b0;
        if (state_q != ST_OFF) begin
            if (rise) begin
                wdt_d = '0;
            end else if (wdt_q == 10'(C_WDT - 1)) begin
                wdt_d   = '0;
                timeout = 1'b1;
            end else begin
                wdt_d = wdt_q + 10'd1;
            end
        end
        unique case (state_q)
            ST_OFF: begin
                state_d = ST_WARM;
                warm_d  = '0;
            end
            ST_WARM: begin
                if (fall) begin
                    if (warm_q == 12'(C_WARM - 1)) begin
                        state_d = ST_RUN;
                        warm_d  = '0;
                        frm_d   = '0;
                    end else begin
                        warm_d = warm_q + 12'd1;
                    end
                end
            end
            ST_RUN: begin
                if (fall) begin
                    mod_upd = 1'b1;
                    frm_d   = (frm_q == 8'(C_DEC - 1)) ? '0 : frm_q + 8'd1;
                    if (frm_q == '0) begin
                        if (cnt_q != '0) begin
                            pop   = 1'b1;
                            cur_d = fifo_q[rd_ptr_q];
                        end else begin
                            status_d[0] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_OFF;
        endcase
        // Clock loss pre-empts any frame activity on the same cycle.
        if (timeout) begin
            state_d  = ST_WARM;
            warm_d   = '0;
            frm_d    = '0;
            status_d = {1'b1, status_q[0]};
            cur_d    = cur_q;
            pop      = 1'b0;
            mod_upd  = 1'b0;
        end
        if (!EN_i) begin
            state_d  = ST_OFF;
            warm_d   = '0;
            frm_d    = '0;
            wdt_d    = '0;
            status_d = '0;
            cur_d    = '0;
            pop      = 1'b0;
            mod_upd  = 1'b0;
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (!EN_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = SMPLs_i;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_d = ~rd_ptr_q;
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // cur_d already holds the freshly popped pair on a frame boundary.
    always_comb begin
        step0 = mod_step(i1_q[0], i2_q[0], y_q[0], cur_d[11:0]);
        step1 = mod_step(i1_q[1], i2_q[1], y_q[1], cur_d[23:12]);
        i1_d  = i1_q;
        i2_d  = i2_q;
        y_d   = y_q;
        if (mod_clr) begin
            i1_d = '{default: '0};
            i2_d = '{default: '0};
            y_d  = '0;
        end else if (mod_upd) begin
            i1_d[0] = step0[15:0];
            i2_d[0] = step0[31:16];
            y_d[0]  = step0[32];
            i1_d[1] = step1[15:0];
            i2_d[1] = step1[31:16];
            y_d[1]  = step1[32];
        end
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state_q  <= ST_OFF;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            edge_q   <= 1'b0;
            warm_q   <= '0;
            frm_q    <= '0;
            wdt_q    <= '0;
            fifo_q   <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
            cur_q    <= '0;
            i1_q     <= '{default: '0};
            i2_q     <= '{default: '0};
            y_q      <= '0;
            status_q <= '0;
            alive_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= MIC_CK_i;
            sync2_q  <= sync1_q;
            edge_q   <= sync2_q;
            warm_q   <= warm_d;
            frm_q    <= frm_d;
            wdt_q    <= wdt_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            i1_q     <= i1_d;
            i2_q     <= i2_d;
            y_q      <= y_d;
            status_q <= status_d;
            alive_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pdm_mic_tx.sv
// Randomized bench for pdm_mic_tx: a transaction-level model (sample queue,
// MIC_CK fall/rise events, integer modulator arithmetic) predicts every cycle.
module tb_pdm_mic_tx;

    localparam int unsigned P_DEC  = 8;
    localparam int unsigned P_WARM = 16;
    localparam int unsigned P_WDT  = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mic = 1'b1;
    logic        en = 1'b0;
    logic        vld = 1'b0;
    logic [23:0] smpl = '0;
    logic        rdy_o;
    logic [1:0]  dat_o;
    logic [1:0]  status_o;

    pdm_mic_tx #(
        .C_DEC  (P_DEC),
        .C_WARM (P_WARM),
        .C_WDT  (P_WDT)
    ) dut (
        .CK_i       (clk),
        .XARST_i    (rst_n),
        .MIC_CK_i   (mic),
        .EN_i       (en),
        .SMPLs_i    (smpl),
        .SMPL_VLD_i (vld),
        .SMPL_RDY_o (rdy_o),
        .MICs_DAT_o (dat_o),
        .STATUSs_o  (status_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    typedef enum {M_OFF, M_WARM, M_RUN} mode_e;
    mode_e       m_st = M_OFF;
    int          warm_n = 0, frame_n = 0, since_rise = 0;
    logic [23:0] q[$];
    logic [23:0] cur = '0;
    int          i1[2], i2[2];
    bit          y[2];
    bit          st_und = 0, st_lost = 0, rst_ok = 0;
    bit          h[4];

    // Stimulus controls
    bit          mic_run = 0;
    int          phase = 4;
    int          vld_mode = 0;
    bit          fixed_mode = 0;
    logic [23:0] fixed_smpl = '0;
    int          pairs_left = 0;
    bit          counting = 0;
    int          ones[2];

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic clear_mod();
        for (int n = 0; n < 2; n++) begin
            i1[n] = 0;
            i2[n] = 0;
            y[n]  = 0;
        end
    endtask

    task automatic modulate();
        logic signed [11:0] xs;
        int yv;
        for (int n = 0; n < 2; n++) begin
            xs    = (n == 0) ? cur[11:0] : cur[23:12];
            yv    = y[n] ? 2048 : -2048;
            i1[n] = clamp16(i1[n] + int'(xs) - yv);
            i2[n] = clamp16(i2[n] + i1[n] - yv);
            y[n]  = (i2[n] >= 0);
        end
    endtask

    task automatic model_reset();
        m_st = M_OFF; warm_n = 0; frame_n = 0; since_rise = 0;
        q.delete(); cur = '0; clear_mod();
        st_und = 0; st_lost = 0; rst_ok = 0;
        for (int k = 0; k < 4; k++) h[k] = 0;
    endtask

    // One CK_i rising edge: MIC_CK events reach the logic three edges after
    // the bench changes the pin (two synchronizer stages plus edge detect).
    task automatic model_edge(input bit push, input logic [23:0] pd);
        bit fall, rise, tmo;
        h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = mic;
        fall = !h[2] && h[3];
        rise = h[2] && !h[3];
        rst_ok = 1;
        if (!en) begin
            m_st = M_OFF; warm_n = 0; frame_n = 0; since_rise = 0;
            q.delete(); cur = '0; clear_mod(); st_und = 0; st_lost = 0;
            return;
        end
        tmo = 0;
        if (m_st != M_OFF) begin
            since_rise = rise ? 0 : since_rise + 1;
            if (since_rise == P_WDT) begin
                tmo = 1;
                since_rise = 0;
            end
        end
        if (tmo) begin
            st_lost = 1; m_st = M_WARM; warm_n = 0; frame_n = 0; clear_mod();
        end else begin
            case (m_st)
                M_OFF: begin m_st = M_WARM; warm_n = 0; end
                M_WARM: if (fall) begin
                    warm_n++;
                    if (warm_n == P_WARM) begin m_st = M_RUN; frame_n = 0; end
                end
                M_RUN: if (fall) begin
                    if (frame_n == 0) begin
                        if (q.size() > 0) cur = q.pop_front();
                        else st_und = 1;
                    end
                    modulate();
                    frame_n = (frame_n + 1) % P_DEC;
                end
                default: ;
            endcase
        end
        if (push) q.push_back(pd);
    endtask

    // Called at a falling CK_i edge; returns at the next falling edge.
    task automatic tick();
        bit exp_rdy, push;
        if (mic_run) begin
            phase = (phase + 1) % 8;
            mic = (phase < 4) ? 1'b0 : 1'b1;
        end
        case (vld_mode)
            1:       vld = 1'($urandom_range(0, 1));
            2:       vld = 1'b1;
            3:       vld = (pairs_left > 0);
            default: vld = 1'b0;
        endcase
        smpl = fixed_mode ? fixed_smpl : 24'($urandom);
        #1;
        exp_rdy = rst_ok && en && (q.size() < 2);
        check("rdy", int'(rdy_o), int'(exp_rdy));
        push = vld && exp_rdy;
        if (push && vld_mode == 3) pairs_left--;
        @(posedge clk);
        model_edge(push, smpl);
        @(negedge clk);
        check("dat", int'(dat_o), int'({y[1], y[0]}));
        check("status", int'(status_o), int'({st_lost, st_und}));
        if (counting && phase == 7) begin
            ones[0] += int'(dat_o[0]);
            ones[1] += int'(dat_o[1]);
        end
    endtask

    task automatic density_run(input logic [23:0] v, input int periods);
        en = 1'b0;
        tick();
        fixed_mode = 1; fixed_smpl = v; vld_mode = 2; en = 1'b1;
        repeat ((P_WARM + 3) * 8) tick();
        ones[0] = 0; ones[1] = 0; counting = 1;
        repeat (periods * 8) tick();
        counting = 0; fixed_mode = 0;
    endtask

    task automatic async_reset_check();
        #2 rst_n = 1'b0;
        #1;
        check("rst_dat", int'(dat_o), 0);
        check("rst_rdy", int'(rdy_o), 0);
        check("rst_status", int'(status_o), 0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int d;
        model_reset();
        #1;
        check("rst_dat", int'(dat_o), 0);
        check("rst_rdy", int'(rdy_o), 0);
        check("rst_status", int'(status_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Random samples with random valid gaps
        mic_run = 1; vld_mode = 1; en = 1'b1;
        repeat ((P_WARM + 40) * 8) tick();

        // Mid-scale densities: ch0 = 0, ch1 = +1024
        density_run(24'h400000, 512);
        d = ones[0] - 256;
        check("dens_ch0_tol", int'(d >= -2 && d <= 2), 1);
        d = ones[1] - 384;
        check("dens_ch1_tol", int'(d >= -2 && d <= 2), 1);

        // Full scale: ch0 = +2047, ch1 = -2048
        density_run(24'h8007FF, 512);
        check("full_pos_dens", int'(ones[0] >= 510), 1);
        check("full_neg_dens", int'(ones[1] <= 2), 1);

        // Underrun: two pairs only, third frame boundary finds FIFO empty
        en = 1'b0; vld_mode = 0;
        tick();
        pairs_left = 2; vld_mode = 3; en = 1'b1;
        repeat ((P_WARM + 3 * P_DEC + 4) * 8) tick();
        check("underrun_flag", int'(status_o[0]), 1);
        en = 1'b0; vld_mode = 0;
        tick();
        check("off_clears_status", int'(status_o), 0);

        // Clock loss mid-RUN with the FIFO filling up
        en = 1'b1; vld_mode = 1;
        repeat ((P_WARM + 10) * 8) tick();
        mic_run = 0; vld_mode = 2;
        repeat (P_WDT - 16) tick();
        check("lost_early", int'(status_o[1]), 0);
        repeat (2 * P_WDT) tick();
        check("lost_set", int'(status_o[1]), 1);
        check("lost_dat", int'(dat_o), 0);
        check("full_rdy", int'(rdy_o), 0);
        mic_run = 1; vld_mode = 1;
        repeat ((P_WARM + 10) * 8) tick();

        // Asynchronous reset mid-frame with a full FIFO
        vld_mode = 2;
        repeat (P_DEC * 8 + 20) tick();
        async_reset_check();
        vld_mode = 1;
        repeat ((P_WARM + 20) * 8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pdm_mic_tx.md
PDM_MIC_TX -- requirements
Module: pdm_mic_tx

Interface
REQ-001 C_DEC, 64, number of MIC_CK periods per input sample pair (decimation ratio), range 2..256.
REQ-002 C_WARM, 1024, number of MIC_CK periods the outputs are held in start-up before modulation begins, range 1..4095.
REQ-003 C_WDT, 255, number of CK_i cycles without a MIC_CK rising edge that counts as clock loss, range 16..1023.
REQ-004 CK_i  in  1  system clock, 48 MHz; the only clock in the block.
REQ-005 XARST_i  in  1  reset, asynchronous assert, active-low.
REQ-006 MIC_CK_i  in  1  PDM bit clock from the host, nominally 4 MHz, asynchronous to CK_i.
REQ-007 EN_i  in  1  enable; low forces the OFF state.
REQ-008 SMPLs_i  in  24  sample pair: [11:0] is channel 0 and [23:12] is channel 1, both 2's-complement -2048..+2047.
REQ-009 SMPL_VLD_i  in  1  sample pair valid.
REQ-010 SMPL_RDY_o  out  1  the block can accept a sample pair.
REQ-011 MICs_DAT_o  out  2  PDM data; bit n belongs to channel n.
REQ-012 STATUSs_o  out  2  sticky flags: [0] UNDERRUN, [1] CK_LOST.

Function
REQ-013 The MIC_CK_i input SHALL be synchronized with 2 flip-flops and then edge-detected into single-cycle RISE and FALL pulses.
REQ-014 The FSM SHALL have three states: OFF, WARM and RUN.
- OFF->WARM: EN_i=1.
- WARM->RUN: after C_WARM FALL pulses.
- Any state->OFF: EN_i=0, taking effect on the next CK_i edge.
- WARM or RUN->WARM: a watchdog timeout occurs.
REQ-015 The watchdog counter SHALL clear on every RISE pulse and count CK_i cycles otherwise, in WARM and RUN only; reaching C_WDT SHALL set CK_LOST, restart the WARM count and clear the integrators.
REQ-016 The input buffer SHALL be a 2-entry FIFO, with SMPL_RDY_o = EN_i & (count<2), and a transfer occurs only when SMPL_VLD_i & SMPL_RDY_o.
REQ-017 Simultaneous push and pop at count 1 SHALL leave the count at 1; a pop at count 0 is an underrun.
REQ-018 In RUN, a frame counter SHALL count FALL pulses 0..C_DEC-1 and wrap; the FALL pulse where the count is 0 is the frame boundary.
- On a frame boundary, the block SHALL pop the FIFO into the current-sample registers.
- The first FALL pulse after entering RUN is a frame boundary.
REQ-019 On a frame boundary with the FIFO empty, the block SHALL keep the previous current sample and set UNDERRUN.
REQ-020 Each channel SHALL have a second-order delta-sigma modulator that updates only on FALL pulses in RUN. It uses the bit y from the previous update, with Y = +2048 if y=1 and -2048 if y=0:
- I1 <= sat16(I1 + x - Y)
- I2 <= sat16(I2 + I1_new - Y)
- y <= (I2_new >= 0)
REQ-021 sat16 SHALL clamp its result to the range -32768..+32767; x SHALL be sign-extended, and all intermediate sums SHALL be at least 18 bits wide.
REQ-022 MICs_DAT_o[n] SHALL be the registered y of channel n, changing 3 CK_i cycles after the MIC_CK_i falling edge and stable through the following high phase.
REQ-023 In OFF and WARM, MICs_DAT_o SHALL be 2'b00, and I1, I2 and y SHALL be held at 0.
REQ-024 Entering OFF SHALL flush the FIFO and clear the frame counter, the WARM counter, the watchdog counter and STATUSs_o.
REQ-025 The status flags SHALL be sticky and cleared only by reset or by OFF; UNDERRUN is never set outside RUN.

Reset
REQ-026 While XARST_i=0, the block SHALL be in OFF with all of the following cleared:
- MICs_DAT_o=2'b00, SMPL_RDY_o=0, STATUSs_o=2'b00.
- FIFO count 0, integrators 0, all counters 0.
- Both synchronizer flip-flops 0.
REQ-027 Reset release SHALL take effect on the first CK_i edge; a reset asserted mid-RUN SHALL discard the FIFO contents and the modulator state immediately.

Verification
REQ-028 MIC_CK_i at 4 MHz, EN_i=1, C_WARM=16 -> MICs_DAT_o=00 for 16 MIC_CK periods, then RUN; SMPL_RDY_o=1 within 1 CK_i of EN_i while the FIFO is not full.
REQ-029 Constant SMPLs_i {ch1=+1024, ch0=0}, always valid, 4096 MIC_CK periods in RUN -> ch0 ones count 2048±2 and ch1 ones count 3072±2; no flags set.
REQ-030 Full-scale +2047 and -2048 held for 8192 MIC_CK periods -> no integrator wrap (ones density ≥4094/4096 and ≤2/4096 respectively).
REQ-031 SMPL_VLD_i withheld after 2 pairs with C_DEC=64 -> the 3rd frame boundary sets STATUSs_o[0] and the output density continues from the last sample; EN_i low then clears the flag.
REQ-032 MIC_CK_i stopped mid-RUN -> STATUSs_o[1]=1 after 255 CK_i cycles, outputs 00, WARM restarts when the clock resumes; FIFO push while full is ignored (SMPL_RDY_o=0).
REQ-033 XARST_i pulsed low mid-frame with a full FIFO -> all outputs at reset values within 0 CK_i cycles; normal restart afterwards.
